cpu_lsu: RTL and testbench

CPU_LSU -- requirements
Module: cpu_lsu

---
 rtl/cpu_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_lsu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_lsu.sv
// Load/store unit: single byte/half/word transfers with extension or
// rotation, and block (register-list) transfers with base writeback.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// XFER  | one memory beat outstanding; held until mem_ok
// DONE  | one-cycle completion; done=1, base_wb final
module cpu_lsu #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_multi,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic [NREGS-1:0]  req_reglist,
    input  logic              req_up,
    input  logic              req_before,
    output logic [IDX_W-1:0]  st_idx,
    input  logic [31:0]       st_data,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [31:0]       wb_data,
    output logic              done,
    output logic [ADDR_W-1:0] base_wb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        mem_width,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ok
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic              multi_q, multi_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [NREGS-1:0]  list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wbv_q, wbv_d;
    logic [IDX_W-1:0]  wbi_q, wbi_d;
    logic [31:0]       wbd_q, wbd_d;

    logic [ADDR_W-1:0] cnt4;
    logic [ADDR_W-1:0] blk_first;
    logic [ADDR_W-1:0] single_addr;
    logic [IDX_W-1:0]  cur_idx;
    logic [NREGS-1:0]  list_rest;
    logic [1:0]        eff_width;
    logic [63:0]       rot;
    logic [31:0]       load_ext;

    // Request decode: popcount, first block address, aligned single address
    always_comb begin
        cnt4 = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt4 = cnt4 + {{(ADDR_W-1){1'b0}}, req_reglist[i]};
        end
        cnt4 = cnt4 << 2;
        case ({req_up, req_before})
            2'b10:   blk_first = req_addr;
            2'b11:   blk_first = req_addr + FOUR;
            2'b00:   blk_first = req_addr - cnt4 + FOUR;
            default: blk_first = req_addr - cnt4;
        endcase
        blk_first = blk_first & ~ADDR_W'(3);
        case (req_size)
            2'd0:    single_addr = req_addr;
            2'd1:    single_addr = req_addr & ~ADDR_W'(1);
            default: single_addr = req_addr & ~ADDR_W'(3);
        endcase
    end

    // Current register: lowest set bit of the remaining list, or rd
    always_comb begin
        cur_idx = rd_q;
        if (multi_q) begin
            cur_idx = '0;
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (list_q[i]) cur_idx = IDX_W'(i);
            end
        end
        list_rest = list_q & (list_q - NREGS'(1));
    end

    // Load data shaping: extend byte/half, rotate misaligned word
    always_comb begin
        eff_width = (multi_q || size_q == 2'd3) ? 2'd2 : size_q;
        rot       = {mem_rdata, mem_rdata} >> {lo_q, 3'b000};
        case (eff_width)
            2'd0:    load_ext = signed_q ? {{24{mem_rdata[7]}}, mem_rdata[7:0]}
                                         : {24'b0, mem_rdata[7:0]};
            2'd1:    load_ext = signed_q ? {{16{mem_rdata[15]}}, mem_rdata[15:0]}
                                         : {16'b0, mem_rdata[15:0]};
            default: load_ext = rot[31:0];
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        multi_d  = multi_q;
        size_d   = size_q;
        signed_d = signed_q;
        rd_d     = rd_q;
        list_d   = list_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        base_d   = base_q;
        wbv_d    = 1'b0;
        wbi_d    = wbi_q;
        wbd_d    = wbd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_d   = req_load;
                    multi_d  = req_multi;
                    size_d   = req_size;
                    signed_d = req_signed;
                    rd_d     = req_rd;
                    list_d   = req_reglist;
                    if (req_multi) begin
                        lo_d    = 2'b00;
                        addr_d  = blk_first;
                        base_d  = req_up ? req_addr + cnt4 : req_addr - cnt4;
                        state_d = (req_reglist == '0) ? DONE : XFER;
                    end else begin
                        lo_d    = req_addr[1:0];
                        addr_d  = single_addr;
                        base_d  = req_addr;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                if (mem_ok) begin
                    wbv_d = load_q;
                    if (load_q) begin
                        wbi_d = cur_idx;
                        wbd_d = load_ext;
                    end
                    list_d = list_rest;
                    addr_d = addr_q + FOUR;
                    if (!multi_q || list_rest == '0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            multi_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            rd_q     <= '0;
            list_q   <= '0;
            addr_q   <= '0;
            lo_q     <= 2'b00;
            base_q   <= '0;
            wbv_q    <= 1'b0;
            wbi_q    <= '0;
            wbd_q    <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            multi_q  <= multi_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            rd_q     <= rd_d;
            list_q   <= list_d;
            addr_q   <= addr_d;
            lo_q     <= lo_d;
            base_q   <= base_d;
            wbv_q    <= wbv_d;
            wbi_q    <= wbi_d;
            wbd_q    <= wbd_d;
        end
    end

    // Output drive; store data only reaches the bus while a store is active
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_read  = (state_q == XFER) && load_q;
        mem_write = (state_q == XFER) && !load_q;
        mem_addr  = addr_q;
        mem_width = eff_width;
        st_idx    = cur_idx;
        mem_wdata = '0;
        if (mem_write) begin
            case (eff_width)
                2'd0:    mem_wdata = {24'b0, st_data[7:0]};
                2'd1:    mem_wdata = {16'b0, st_data[15:0]};
                default: mem_wdata = st_data;
            endcase
        end
        wb_valid = wbv_q;
        wb_idx   = wbi_q;
        wb_data  = wbd_q;
        done     = (state_q == DONE);
        base_wb  = base_q;
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: directed scenarios plus randomized requests checked
// against a transaction-level model of addresses, data and base writeback.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_multi;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [3:0]  req_rd;
    logic [15:0] req_reglist;
    logic        req_up, req_before;
    logic [3:0]  st_idx;
    logic [31:0] st_data;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done;
    logic [31:0] base_wb, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read, mem_write, mem_ok;

    logic [31:0] regs [16];
    logic [31:0] last_wb;
    int          n_checks = 0;
    int          n_errors = 0;

    assign st_data = regs[st_idx];

    always #5 clk = ~clk;

    cpu_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_multi(req_multi),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_rd(req_rd), .req_reglist(req_reglist),
        .req_up(req_up), .req_before(req_before),
        .st_idx(st_idx), .st_data(st_data),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .done(done), .base_wb(base_wb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_width(mem_width), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ok(mem_ok)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] r, input int s);
        if (s == 0) return r;
        return (r >> s) | (r << (32 - s));
    endfunction

    function automatic logic [31:0] model_load(input bit mul, input int w, input bit sg,
                                               input logic [1:0] lo, input logic [31:0] r);
        if (mul) return r;
        if (w == 0) return (sg && r[7])  ? (32'hFFFFFF00 | (r & 32'hFF))   : (r & 32'hFF);
        if (w == 1) return (sg && r[15]) ? (32'hFFFF0000 | (r & 32'hFFFF)) : (r & 32'hFFFF);
        return rotr(r, 8 * int'(lo));
    endfunction

    function automatic logic [31:0] model_store(input int w, input logic [31:0] d);
        if (w == 0) return d & 32'hFF;
        if (w == 1) return d & 32'hFFFF;
        return d;
    endfunction

    task automatic scramble_req();
        req_addr    = $urandom;
        req_reglist = 16'($urandom);
        req_size    = 2'($urandom);
        req_rd      = 4'($urandom);
        req_signed  = 1'($urandom);
        req_up      = 1'($urandom);
        req_before  = 1'($urandom);
        req_load    = 1'($urandom);
        req_multi   = 1'($urandom);
    endtask

    task automatic run_req(input bit ld, input bit mul, input logic [31:0] a,
                           input logic [1:0] sz, input bit sg, input logic [3:0] rd,
                           input logic [15:0] rl, input bit up, input bit bf,
                           input int dly, input bit fix, input logic [31:0] rfix);
        logic [31:0] ea[$];
        int          ei[$];
        logic [31:0] first, base_e, rdv, expd;
        int          n, w, wt;
        if (mul) begin
            n = $countones(rl);
            case ({up, bf})
                2'b10:   first = a;
                2'b11:   first = a + 32'd4;
                2'b00:   first = a - 32'(4 * n) + 32'd4;
                default: first = a - 32'(4 * n);
            endcase
            for (int i = 0; i < 16; i++) begin
                if (rl[i]) begin
                    ea.push_back((first + 32'(4 * ei.size())) & 32'hFFFFFFFC);
                    ei.push_back(i);
                end
            end
            base_e = up ? a + 32'(4 * n) : a - 32'(4 * n);
            w = 2;
        end else begin
            n = 1;
            w = (sz == 2'd3) ? 2 : int'(sz);
            ea.push_back(w == 0 ? a : (w == 1 ? (a & 32'hFFFFFFFE) : (a & 32'hFFFFFFFC)));
            ei.push_back(int'(rd));
            base_e = a;
        end

        req_valid = 1'b1; req_load = ld; req_multi = mul; req_addr = a; req_size = sz;
        req_signed = sg; req_rd = rd; req_reglist = rl; req_up = up; req_before = bf;
        check("ready_idle", req_ready, 1);
        tick();
        scramble_req();
        req_valid = 1'($urandom);

        if (n == 0) begin
            check("empty_done", done, 1);
            check("empty_rd", mem_read, 0);
            check("empty_wr", mem_write, 0);
            check("empty_base", base_wb, a);
            req_valid = 1'b0;
            tick();
            check("empty_ready", req_ready, 1);
            check("empty_done_low", done, 0);
            return;
        end

        for (int k = 0; k < n; k++) begin
            wt = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
            for (int c = 0; c <= wt; c++) begin
                check("busy", req_ready, 0);
                check("mem_read", mem_read, ld);
                check("mem_write", mem_write, !ld);
                check("mem_addr", mem_addr, ea[k]);
                check("mem_width", mem_width, w);
                check("done_busy", done, 0);
                if (!ld) begin
                    check("st_idx", st_idx, ei[k]);
                    check("mem_wdata", mem_wdata, model_store(w, regs[ei[k]]));
                end
                rdv = fix ? rfix : $urandom;
                mem_rdata = rdv;
                mem_ok = (c == wt);
                if (k == n - 1 && c == wt) req_valid = 1'b0;
                tick();
                mem_ok = 1'b0;
                if (c == wt && ld) begin
                    expd = model_load(mul, w, sg, a[1:0], rdv);
                    check("wb_valid", wb_valid, 1);
                    check("wb_idx", wb_idx, ei[k]);
                    check("wb_data", wb_data, expd);
                    last_wb = wb_data;
                end else begin
                    check("wb_quiet", wb_valid, 0);
                end
            end
        end
        check("done", done, 1);
        check("base_wb", base_wb, base_e);
        tick();
        check("done_low", done, 0);
        check("ready_after", req_ready, 1);
        check("wb_after", wb_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_rd"}, mem_read, 0);
        check({tag, "_wr"}, mem_write, 0);
        check({tag, "_wbv"}, wb_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wbi"}, wb_idx, 0);
        check({tag, "_wbd"}, wb_data, 0);
        check({tag, "_base"}, base_wb, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_ok = 1'b0; mem_rdata = '0;
        scramble_req();
        last_wb = '0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        tick();
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // signed byte load
        run_req(1, 0, 32'h03000001, 2'd0, 1, 4'd5, 16'h0, 0, 0, 0, 1, 32'h00000080);
        check("sbyte_const", last_wb, 32'hFFFFFF80);
        // misaligned word load rotates
        run_req(1, 0, 32'h02000002, 2'd2, 0, 4'd2, 16'h0, 0, 0, 0, 1, 32'h11223344);
        check("word_const", last_wb, 32'h33441122);
        // block load ascending, mem_ok held
        run_req(1, 1, 32'h00000100, 2'd0, 0, 4'd0, 16'h000B, 1, 0, 0, 0, 32'h0);
        check("blk_base_const", base_wb, 32'h0000010C);
        // block store decrement-before with slow memory
        run_req(0, 1, 32'h00000200, 2'd0, 0, 4'd0, 16'h8001, 0, 1, 2, 0, 32'h0);
        check("blkst_base_const", base_wb, 32'h000001F8);
        // empty list
        run_req(1, 1, 32'h00000300, 2'd0, 0, 4'd0, 16'h0000, 1, 0, 0, 0, 32'h0);
        // size 3 behaves as word, store halfword, wrap-around block
        run_req(1, 0, 32'h00000007, 2'd3, 1, 4'd9, 16'h0, 0, 0, 1, 0, 32'h0);
        run_req(0, 0, 32'h00001003, 2'd1, 0, 4'd7, 16'h0, 0, 0, 0, 0, 32'h0);
        run_req(1, 1, 32'h00000004, 2'd0, 0, 4'd0, 16'h00F0, 0, 1, -1, 0, 32'h0);

        // reset during second beat of a 3-register load
        req_valid = 1'b1; req_load = 1'b1; req_multi = 1'b1; req_addr = 32'h400;
        req_reglist = 16'h0007; req_up = 1'b1; req_before = 1'b0;
        tick();
        req_valid = 1'b0;
        mem_ok = 1'b1; mem_rdata = $urandom;
        tick();
        check("abort_beat2_addr", mem_addr, 32'h404);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("abort_wb", wb_valid, 0);
            check("abort_done", done, 0);
            check("abort_rd", mem_read, 0);
            check("abort_ready", req_ready, 1);
            tick();
        end
        mem_ok = 1'b0;
        run_req(1, 1, 32'h00000500, 2'd0, 0, 4'd0, 16'h0006, 1, 1, -1, 0, 32'h0);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [15:0] rl;
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rl = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            run_req(1'($urandom), 1'($urandom), a, 2'($urandom), 1'($urandom),
                    4'($urandom), rl, 1'($urandom), 1'($urandom), -1, 0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
